if_stage: RTL and testbench

- Instruction fetch stage of the 5-stage CPU; sits directly upstream of the decode stage.
- Generates fetch addresses and runs a level-handshake read of instruction memory.
- Buffers a returned word when the pipeline is stalled.
- Drives the IF/ID pipeline register (if_pc, if_insn, if_en) consumed by decode.
- Applies branch redirects from decode and flush/new_pc redirects from the pipeline control unit.

---
 rtl/if_stage.sv | 109 ++++++++++
 tb/tb_if_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: issues level-handshake reads of instruction memory,
// buffers a returned word across stalls and drives the IF/ID pipeline register.
module if_stage #(
    parameter logic [29:0] RESET_PC = 30'h0,
    parameter logic [31:0] ISA_NOP  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    output logic        busy,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rd_data,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en
);

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e      state_q, state_d;
    logic [29:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_insn_q, hold_insn_d;
    logic [29:0] if_pc_d;
    logic [31:0] if_insn_d;
    logic        if_en_d;
    logic        advance;
    logic [31:0] adv_insn;
    logic [29:0] seq_pc;

    assign imem_req  = (state_q == StReq);
    assign imem_addr = fetch_pc_q;
    assign busy      = (state_q == StReq) & ~imem_rdy;

    // Branch target replaces only the next fetch address; the current word is the delay slot.
    assign seq_pc = br_taken ? br_addr : fetch_pc_q + 30'd1;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_insn_d = hold_insn_q;
        if_pc_d     = if_pc;
        if_insn_d   = if_insn;
        if_en_d     = if_en;
        advance     = 1'b0;
        adv_insn    = imem_rd_data;

        if (flush) begin
            if_en_d    = 1'b0;
            if_insn_d  = ISA_NOP;
            fetch_pc_d = new_pc;
            state_d    = StReq;
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (imem_rdy) begin
                        if (stall) begin
                            hold_insn_d = imem_rd_data;
                            state_d     = StHold;
                        end else begin
                            advance  = 1'b1;
                            adv_insn = imem_rd_data;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        advance  = 1'b1;
                        adv_insn = hold_insn_q;
                        state_d  = StReq;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (advance) begin
                if_pc_d    = fetch_pc_q;
                if_insn_d  = adv_insn;
                if_en_d    = 1'b1;
                fetch_pc_d = seq_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            hold_insn_q <= 32'h0;
            if_pc       <= RESET_PC;
            if_insn     <= ISA_NOP;
            if_en       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_insn_q <= hold_insn_d;
            if_pc       <= if_pc_d;
            if_insn     <= if_insn_d;
            if_en       <= if_en_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a tagged-data memory model with controllable ready
// and data scrambling, checked against hand-computed IF/ID contents.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] new_pc = '0;
    logic        br_taken = 1'b0;
    logic [29:0] br_addr = '0;
    logic        busy;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rd_data;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;

    logic        mem_rdy = 1'b1;
    logic [31:0] mem_xor = '0;
    int          checks = 0;
    int          fails = 0;

    assign imem_rdy     = mem_rdy;
    assign imem_rd_data = (32'hA000_0000 | {2'b00, imem_addr}) ^ mem_xor;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(30'h0), .ISA_NOP(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr), .busy(busy), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rd_data(imem_rd_data),
        .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (if_en !== 1'b0) begin fails++; $display("FAIL rst_en got %b want 0", if_en); end
        checks++; if (if_pc !== 30'h0) begin fails++; $display("FAIL rst_pc got %h want 0", if_pc); end
        checks++; if (if_insn !== 32'h0) begin fails++; $display("FAIL rst_insn got %h want 0", if_insn); end
        reset = 1'b0;
        step();
        checks++; if (if_en !== 1'b0 || imem_req !== 1'b1) begin
            fails++; $display("FAIL first_edge got en=%b req=%b want en=0 req=1", if_en, imem_req);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_en !== 1'b1 || if_pc !== 30'(i) || if_insn !== (32'hA000_0000 | 32'(i))) begin
                fails++;
                $display("FAIL stream%0d got en=%b pc=%h insn=%h want 1 %h %h", i, if_en, if_pc,
                         if_insn, i, 32'hA000_0000 | 32'(i));
            end
        end
    endtask

    task automatic test_wait();
        step();  // delivers 3
        step();  // delivers 4, now requesting 5
        mem_rdy = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy !== 1'b1 || imem_addr !== 30'h5 || if_pc !== 30'h4) begin
                fails++;
                $display("FAIL wait%0d got busy=%b addr=%h pc=%h want 1 5 4", i, busy, imem_addr, if_pc);
            end
            if (i == 0) step();
        end
        mem_rdy = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wait_rdy busy got %b want 0", busy); end
        step();
        checks++;
        if (if_pc !== 30'h5 || if_insn !== 32'hA000_0005 || imem_addr !== 30'h6) begin
            fails++;
            $display("FAIL wait_done got pc=%h insn=%h addr=%h want 5 a0000005 6", if_pc, if_insn,
                     imem_addr);
        end
    endtask

    task automatic test_stall_hold();
        step();  // delivers 6, now requesting 7
        stall = 1'b1;
        step();  // captures word at 7 into hold
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || if_pc !== 30'h6) begin
            fails++;
            $display("FAIL hold_enter got req=%b busy=%b pc=%h want 0 0 6", imem_req, busy, if_pc);
        end
        mem_xor = 32'h0000_FFFF;
        step();
        step();
        checks++; if (if_pc !== 30'h6) begin fails++; $display("FAIL hold_keep pc got %h want 6", if_pc); end
        stall = 1'b0;
        step();
        checks++;
        if (if_pc !== 30'h7 || if_insn !== 32'hA000_0007 || imem_addr !== 30'h8 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL hold_release got pc=%h insn=%h addr=%h req=%b want 7 a0000007 8 1", if_pc,
                     if_insn, imem_addr, imem_req);
        end
        mem_xor = '0;
    endtask

    task automatic test_branch();
        flush = 1'b1;
        new_pc = 30'h4;
        step();
        flush = 1'b0;
        br_taken = 1'b1;
        br_addr = 30'h100;
        step();
        br_taken = 1'b0;
        checks++;
        if (if_pc !== 30'h4 || if_insn !== 32'hA000_0004 || if_en !== 1'b1 || imem_addr !== 30'h100) begin
            fails++;
            $display("FAIL branch_slot got pc=%h insn=%h en=%b addr=%h want 4 a0000004 1 100", if_pc,
                     if_insn, if_en, imem_addr);
        end
        step();
        checks++;
        if (if_pc !== 30'h100 || if_insn !== 32'hA000_0100) begin
            fails++;
            $display("FAIL branch_target got pc=%h insn=%h want 100 a0000100", if_pc, if_insn);
        end
    endtask

    task automatic test_flush();
        stall = 1'b1;
        flush = 1'b1;
        new_pc = 30'h20;
        br_taken = 1'b1;
        br_addr = 30'h55;
        step();
        flush = 1'b0;
        br_taken = 1'b0;
        checks++;
        if (if_en !== 1'b0 || if_insn !== 32'h0 || if_pc !== 30'h100) begin
            fails++;
            $display("FAIL flush_regs got en=%b insn=%h pc=%h want 0 0 100", if_en, if_insn, if_pc);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'h20) begin
            fails++;
            $display("FAIL flush_redirect got req=%b addr=%h want 1 20", imem_req, imem_addr);
        end
        stall = 1'b0;
        step();
        checks++;
        if (if_en !== 1'b1 || if_pc !== 30'h20 || if_insn !== 32'hA000_0020) begin
            fails++;
            $display("FAIL flush_next got en=%b pc=%h insn=%h want 1 20 a0000020", if_en, if_pc, if_insn);
        end
    endtask

    task automatic test_wrap();
        flush = 1'b1;
        new_pc = 30'h3FFF_FFFF;
        step();
        flush = 1'b0;
        step();
        checks++;
        if (if_pc !== 30'h3FFF_FFFF || if_insn !== 32'hBFFF_FFFF || imem_addr !== 30'h0) begin
            fails++;
            $display("FAIL wrap got pc=%h insn=%h addr=%h want 3fffffff bfffffff 0", if_pc, if_insn,
                     imem_addr);
        end
    endtask

    task automatic test_async_reset();
        mem_rdy = 1'b0;
        step();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL pre_reset busy got %b want 1", busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || if_en !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got req=%b busy=%b en=%b want 0 0 0", imem_req, busy, if_en);
        end
        checks++;
        if (if_pc !== 30'h0 || if_insn !== 32'h0 || imem_addr !== 30'h0) begin
            fails++;
            $display("FAIL async_reset_vals got pc=%h insn=%h addr=%h want 0 0 0", if_pc, if_insn,
                     imem_addr);
        end
        mem_rdy = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        checks++;
        if (if_en !== 1'b1 || if_pc !== 30'h0 || if_insn !== 32'hA000_0000) begin
            fails++;
            $display("FAIL post_reset got en=%b pc=%h insn=%h want 1 0 a0000000", if_en, if_pc, if_insn);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait();
        test_stall_hold();
        test_branch();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
